// File: rtl/ras_circular.sv
// Return-address stack on a circular buffer; push past full overwrites the oldest entry and sets sticky ovf.
// Outputs top_of_stack/valid/count are combinational from state; err reflects the current cycle's pop.
// Optional checkpoint (ifdef RAS_CIRCULAR_CKPT_EN) adds ckpt_save/ckpt_restore and a shadow {ptr,cnt}.
module ras_circular #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] new_data,
  input  logic              pop,
  input  logic              flush,
  input  logic              ovf_clr,
`ifdef RAS_CIRCULAR_CKPT_EN
  input  logic              ckpt_save,
  input  logic              ckpt_restore,
`endif
  output logic [DATA_W-1:0] top_of_stack,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              err,
  output logic              ovf
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr, nxt_ptr, ptr_inc, wr_addr;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic              wr_en, ovf_set, empty, full;

  assign ptr_inc = ptr + PTR_W'(1);
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));

  assign top_of_stack = empty ? '0 : mem[ptr];
  assign valid        = !empty;
  assign count        = cnt;

`ifdef RAS_CIRCULAR_CKPT_EN
  logic [PTR_W-1:0] shd_ptr;
  logic [CNT_W-1:0] shd_cnt;

  // Shadow captures pre-update pointer state; a simultaneous restore consumes the old shadow instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_ptr <= '0;
      shd_cnt <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      shd_ptr <= ptr;
      shd_cnt <= cnt;
    end
  end
`endif

  // Next-state decode: flush, then restore, then push/pop combinations.
  always_comb begin
    nxt_ptr = ptr;
    nxt_cnt = cnt;
    wr_en   = 1'b0;
    wr_addr = ptr;
    ovf_set = 1'b0;
    err     = 1'b0;
    if (flush) begin
      nxt_ptr = '0;
      nxt_cnt = '0;
    end
`ifdef RAS_CIRCULAR_CKPT_EN
    else if (ckpt_restore) begin
      nxt_ptr = shd_ptr;
      nxt_cnt = shd_cnt;
    end
`endif
    else if (push && (!pop || empty)) begin
      // Plain push (or push+pop on empty): advance and write the new top.
      nxt_ptr = ptr_inc;
      wr_en   = 1'b1;
      wr_addr = ptr_inc;
      if (full) ovf_set = 1'b1;
      else      nxt_cnt = cnt + CNT_W'(1);
    end else if (push && pop) begin
      // Replace the top in place.
      wr_en   = 1'b1;
      wr_addr = ptr;
    end else if (pop) begin
      if (empty) begin
        err = 1'b1;
      end else begin
        nxt_ptr = ptr - PTR_W'(1);
        nxt_cnt = cnt - CNT_W'(1);
      end
    end
  end

  // Pointer, count and sticky overflow state; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ptr <= nxt_ptr;
      cnt <= nxt_cnt;
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  // Entry storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= new_data;
  end

endmodule

// File: doc/ras_circular.md
RAS_CIRCULAR -- requirements
Module: ras_circular

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of a return-address entry.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of entries; a power of two, at least 2.
REQ-003 The block SHALL derive PTR_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1) internally; neither is overridable.
REQ-004 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port push, input, 1, which writes new_data as the new top.
REQ-007 The block SHALL have port new_data, input, DATA_W, the address to push.
REQ-008 The block SHALL have port pop, input, 1, which removes the top entry.
REQ-009 The block SHALL have port flush, input, 1, which empties the stack.
REQ-010 The block SHALL have port ovf_clr, input, 1, which clears the sticky ovf flag.
REQ-011 The block SHALL have port top_of_stack, output, DATA_W, the current top entry.
REQ-012 The block SHALL have port valid, output, 1, which is high when count is nonzero.
REQ-013 The block SHALL have port count, output, CNT_W, the number of live entries (0..DEPTH).
REQ-014 The block SHALL have port err, output, 1, a combinational underflow indication.
REQ-015 The block SHALL have port ovf, output, 1, a sticky flag set when a live entry is overwritten.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH x DATA_W entries with top pointer ptr (PTR_W bits) and counter cnt (CNT_W bits); ptr arithmetic SHALL wrap modulo DEPTH.
REQ-017 top_of_stack SHALL be combinational: mem[ptr] when cnt>0, else all zeros; valid SHALL be (cnt!=0); count SHALL be cnt.
REQ-018 Priority SHALL be: flush > ckpt_restore (when compiled in) > push/pop.
REQ-019 On flush, the next state SHALL be cnt=0 and ptr=0; memory contents are unchanged and push/pop are ignored that cycle.
REQ-020 On push only, the block SHALL set ptr<=ptr+1, write mem[ptr+1]<=new_data, and set cnt<=min(cnt+1,DEPTH).
REQ-021 On push only with cnt==DEPTH, the oldest entry SHALL be overwritten, cnt SHALL stay DEPTH, ovf SHALL be set, and err SHALL stay low.
REQ-022 On pop only with cnt>0, the block SHALL set ptr<=ptr-1 and cnt<=cnt-1; on pop only with cnt==0, err SHALL be 1 in the same cycle and the state SHALL not change.
REQ-023 On push and pop together with cnt>0, the block SHALL replace the top (mem[ptr]<=new_data) with ptr and cnt unchanged and err low.
REQ-024 On push and pop together with cnt==0, the block SHALL behave as push only and err SHALL be low.
REQ-025 err SHALL be low whenever flush or ckpt_restore is active.
REQ-026 ovf SHALL be set by REQ-021 and cleared by ovf_clr; a set and a clear in the same cycle SHALL leave ovf set.
REQ-027 An op following an overflow wrap SHALL see only the DEPTH most recent pushes; popping DEPTH times SHALL return them newest-first, and a further pop SHALL raise err.

Reset
REQ-028 While rst_n is low, asynchronously: ptr=0, cnt=0, ovf=0, and shadow ptr/cnt=0 (when compiled in); mem SHALL not be reset.
REQ-029 Outputs during and directly after reset SHALL be top_of_stack=0, valid=0, count=0, err=0 (absent pop), and ovf=0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight push/pop; the first post-reset cycle SHALL behave as an empty stack.

Configuration
REQ-031 Macro RAS_CIRCULAR_CKPT_EN defined: the block SHALL add inputs ckpt_save (1) and ckpt_restore (1) and a shadow {ptr,cnt} register.
REQ-032 With the macro, ckpt_save SHALL copy the current (pre-update) ptr/cnt into the shadow, and ckpt_restore SHALL load ptr/cnt from the shadow in place of push/pop.
REQ-033 With the macro, when ckpt_save and ckpt_restore are both high, restore SHALL use the old shadow and the shadow SHALL not update; mem SHALL not be restored.
REQ-034 Macro undefined: the ports and shadow SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-035 Scenario: DEPTH=8, reset, then push 0x1000..0x1002 -> count=3 and top=0x1002; pop x3 -> tops 0x1001, 0x1000, then valid=0 and top=0.
REQ-036 Scenario: push 9 values 0x0001..0x0009 -> count=8, ovf=1, top=0x0009; 8 pops return 0x0009..0x0002; 9th pop -> err=1 and count stays 0.
REQ-037 Scenario: count=2 with top 0xAAAA, push+pop with 0xBBBB -> count=2 and top=0xBBBB; one pop -> the previous entry.
REQ-038 Scenario: pop on empty -> err=1 that cycle only with no state change; push+pop on empty with 0x1234 -> count=1, top=0x1234, err=0.
REQ-039 Scenario: flush with push asserted at count=5 -> count=0 and valid=0; ovf_clr with an overflowing push in the same cycle -> ovf=1.
REQ-040 Scenario (CKPT_EN): save at count=3/top 0x0C00, then push 0x0D00 and pop x2 -> restore gives count=3 and top=mem[saved ptr]; rst_n low mid-sequence -> count=0 immediately.
